// File: rtl/hamnhan_seq.sv
// AXI4-Lite master that runs one multiply job on the memory-mapped multiplier:
// writes A, B, START, polls DONE, reads P and returns the product with an error flag.
module hamnhan_seq #(
  parameter logic [31:0] BASE_ADDR  = 32'h7c80_0000,
  parameter logic [7:0]  POLL_LIMIT = 8'd255
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,

  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_a,
  input  logic [15:0] job_b,

  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_p,
  output logic        res_err,

  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_A     = 3'd1;
  localparam logic [2:0] S_WR_B     = 3'd2;
  localparam logic [2:0] S_WR_START = 3'd3;
  localparam logic [2:0] S_RD_DONE  = 3'd4;
  localparam logic [2:0] S_RD_P     = 3'd5;
  localparam logic [2:0] S_RESP     = 3'd6;

  localparam logic [31:0] ADDR_A     = BASE_ADDR + 32'h0;
  localparam logic [31:0] ADDR_B     = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_START = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADDR_P     = BASE_ADDR + 32'hC;
  localparam logic [31:0] ADDR_DONE  = BASE_ADDR + 32'h10;

  logic [2:0]  state;
  logic [15:0] op_b;
  logic [7:0]  poll_cnt;
  logic        aw_done;
  logic        w_done;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic aw_done_n;
  logic w_done_n;

  assign aw_hs     = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs      = M_AXI_WVALID  && M_AXI_WREADY;
  assign b_hs      = M_AXI_BVALID  && M_AXI_BREADY;
  assign ar_hs     = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs      = M_AXI_RVALID  && M_AXI_RREADY;
  assign aw_done_n = aw_done || aw_hs;
  assign w_done_n  = w_done  || w_hs;

  assign job_ready   = (state == S_IDLE);
  assign res_valid   = (state == S_RESP);
  assign M_AXI_WSTRB = 4'hF;

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch sees the pre-edge values; later assignments in the block take priority.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state         <= S_IDLE;
      op_b          <= '0;
      poll_cnt      <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      res_p         <= '0;
      res_err       <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            op_b          <= job_b;
            poll_cnt      <= '0;
            res_p         <= '0;
            res_err       <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            M_AXI_AWADDR  <= ADDR_A;
            M_AXI_WDATA   <= {16'b0, job_a};
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= S_WR_A;
          end
        end

        S_WR_A, S_WR_B, S_WR_START: begin
          if (aw_hs) M_AXI_AWVALID <= 1'b0;
          if (w_hs)  M_AXI_WVALID  <= 1'b0;
          aw_done <= aw_done_n;
          w_done  <= w_done_n;
          if (aw_done_n && w_done_n && !M_AXI_BREADY) M_AXI_BREADY <= 1'b1;

          if (b_hs) begin
            M_AXI_BREADY <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            if (M_AXI_BRESP != 2'b00) begin
              res_err <= 1'b1;
              res_p   <= '0;
              state   <= S_RESP;
            end else if (state == S_WR_A) begin
              M_AXI_AWADDR  <= ADDR_B;
              M_AXI_WDATA   <= {16'b0, op_b};
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= S_WR_B;
            end else if (state == S_WR_B) begin
              M_AXI_AWADDR  <= ADDR_START;
              M_AXI_WDATA   <= 32'h1;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= S_WR_START;
            end else begin
              M_AXI_ARADDR  <= ADDR_DONE;
              M_AXI_ARVALID <= 1'b1;
              state         <= S_RD_DONE;
            end
          end
        end

        S_RD_DONE, S_RD_P: begin
          if (ar_hs) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
          end
          if (r_hs) begin
            M_AXI_RREADY <= 1'b0;
            if (M_AXI_RRESP != 2'b00) begin
              res_err <= 1'b1;
              res_p   <= '0;
              state   <= S_RESP;
            end else if (state == S_RD_P) begin
              res_p <= M_AXI_RDATA;
              state <= S_RESP;
            end else if (M_AXI_RDATA[0]) begin
              M_AXI_ARADDR  <= ADDR_P;
              M_AXI_ARVALID <= 1'b1;
              state         <= S_RD_P;
            end else if (poll_cnt < POLL_LIMIT) begin
              // DONE still low: re-issue the same read back-to-back
              poll_cnt      <= poll_cnt + 8'd1;
              M_AXI_ARVALID <= 1'b1;
            end else begin
              res_err <= 1'b1;
              res_p   <= '0;
              state   <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (res_ready) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamnhan_seq.sv
// Directed bench for hamnhan_seq with a behavioural AXI4-Lite multiplier slave
// whose handshake delays, DONE polling and error responses are configurable.
module tb_hamnhan_seq;

  localparam logic [31:0] BASE = 32'h7c80_0000;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [15:0] job_a = '0;
  logic [15:0] job_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_p;
  logic        res_err;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hamnhan_seq #(.BASE_ADDR(BASE), .POLL_LIMIT(8'd3)) dut (
    .M_AXI_ACLK(clk),       .M_AXI_ARESET(areset),
    .job_valid(job_valid),  .job_ready(job_ready),
    .job_a(job_a),          .job_b(job_b),
    .res_valid(res_valid),  .res_ready(res_ready),
    .res_p(res_p),          .res_err(res_err),
    .M_AXI_AWADDR(awaddr),  .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata),    .M_AXI_WSTRB(wstrb),     .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),  .M_AXI_BRESP(bresp),     .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),  .M_AXI_ARADDR(araddr),   .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),.M_AXI_RDATA(rdata),     .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid),  .M_AXI_RREADY(rready)
  );

  // ---------------- slave model configuration and observation ----------------
  int          cfg_aw_delay = 0;
  int          cfg_done_zeros = 0;
  bit          cfg_never_done = 1'b0;
  logic [31:0] cfg_err_addr = 32'h0;

  int          wr_count = 0;
  int          done_reads = 0;
  int          p_reads = 0;
  int          stab_err = 0;
  logic [31:0] wr_addr_log [8];
  logic [31:0] wr_data_log [8];

  // Slave: samples the bus at the negedge (handshakes due at the next posedge),
  // then updates its own outputs 1 time unit after that posedge.
  initial begin
    logic        s_rst, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        p_awv, p_wv, p_arv;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic        aw_have, w_have, ar_have;
    logic [31:0] cur_awaddr, cur_wdata, cur_araddr;
    logic [31:0] reg_a, reg_b, product;
    int          aw_cnt, done_left;
    aw_have = 0; w_have = 0; ar_have = 0; aw_cnt = 0; done_left = 0;
    reg_a = 0; reg_b = 0; product = 0;
    cur_awaddr = 0; cur_wdata = 0; cur_araddr = 0;
    forever begin
      @(negedge clk);
      s_rst = areset;
      aw_hs = awvalid && awready;  w_hs = wvalid && wready;
      b_hs  = bvalid && bready;    ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      p_awv = awvalid; p_wv = wvalid; p_arv = arvalid;
      p_awaddr = awaddr; p_wdata = wdata; p_araddr = araddr;
      @(posedge clk);
      #1;
      if (s_rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_have = 0; w_have = 0; ar_have = 0; aw_cnt = 0; done_left = 0;
      end else begin
        if (p_awv && !aw_hs && !(awvalid && awaddr == p_awaddr)) stab_err++;
        if (p_wv && !w_hs && !(wvalid && wdata == p_wdata)) stab_err++;
        if (p_arv && !ar_hs && !(arvalid && araddr == p_araddr)) stab_err++;

        if (b_hs) bvalid = 0;
        if (aw_hs) begin awready = 0; aw_have = 1; cur_awaddr = p_awaddr; aw_cnt = 0; end
        if (w_hs)  begin wready = 0;  w_have = 1;  cur_wdata = p_wdata; end
        if (aw_have && w_have && !bvalid) begin
          if (wr_count < 8) begin
            wr_addr_log[wr_count] = cur_awaddr;
            wr_data_log[wr_count] = cur_wdata;
          end
          wr_count++;
          if (cur_awaddr == BASE)              reg_a = cur_wdata;
          else if (cur_awaddr == BASE + 32'h4) reg_b = cur_wdata;
          else if (cur_awaddr == BASE + 32'h8) begin
            product = reg_a * reg_b;
            done_left = cfg_done_zeros;
          end
          bresp = (cur_awaddr == cfg_err_addr) ? 2'b10 : 2'b00;
          bvalid = 1; aw_have = 0; w_have = 0;
        end
        if (awvalid && !aw_have) begin
          awready = (aw_cnt >= cfg_aw_delay);
          aw_cnt++;
        end else awready = 0;
        wready = wvalid && !w_have;

        if (r_hs) rvalid = 0;
        if (ar_hs) begin arready = 0; ar_have = 1; cur_araddr = p_araddr; end
        if (ar_have && !rvalid) begin
          rresp = 2'b00;
          if (cur_araddr == BASE + 32'h10) begin
            done_reads++;
            if (cfg_never_done || done_left > 0) begin
              rdata = 32'h0;
              if (done_left > 0) done_left--;
            end else rdata = 32'h1;
          end else if (cur_araddr == BASE + 32'hC) begin
            p_reads++;
            rdata = product;
          end else rdata = 32'hDEAD_BEEF;
          rvalid = 1; ar_have = 0;
        end
        arready = arvalid && !ar_have;
      end
    end
  end

  // ---------------- job helpers ----------------
  task automatic clear_log();
    wr_count = 0; done_reads = 0; p_reads = 0; stab_err = 0;
  endtask

  task automatic start_job(input logic [15:0] a, input logic [15:0] b, output bit ok);
    ok = 0;
    @(negedge clk);
    job_a = a; job_b = b; job_valid = 1;
    for (int i = 0; i < 50; i++) begin
      if (job_ready) begin
        @(posedge clk);
        #1;
        job_valid = 0;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    job_valid = 0;
    if (!ok) begin
      errors++;
      $display("FAIL accept: job_ready never seen high");
    end
    checks++;
  endtask

  task automatic wait_result(output int lat, output logic [31:0] p, output logic e);
    bit ok;
    ok = 0; lat = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (res_valid) begin ok = 1; break; end
    end
    p = res_p; e = res_err;
    if (!ok) begin
      errors++;
      $display("FAIL res_timeout: res_valid not seen within %0d edges", lat);
    end
    checks++;
  endtask

  task automatic finish_res();
    @(negedge clk);
    res_ready = 1;
    @(posedge clk);
    #1;
    res_ready = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    areset = 1;
    repeat (2) @(posedge clk);
    #1;
    if ({awvalid, wvalid, bready, arvalid, rready, res_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_valids: got %b expected 000000",
               {awvalid, wvalid, bready, arvalid, rready, res_valid});
    end
    checks++;
    if (job_ready !== 1'b1) begin
      errors++; $display("FAIL reset_job_ready: got %b expected 1", job_ready);
    end
    checks++;
    if ({res_p, res_err, awaddr, araddr, wdata, wstrb} !== {32'h0, 1'b0, 96'h0, 4'hF}) begin
      errors++;
      $display("FAIL reset_regs: res_p=%h err=%b aw=%h ar=%h wd=%h strb=%h",
               res_p, res_err, awaddr, araddr, wdata, wstrb);
    end
    checks++;
    areset = 0;
  endtask

  task automatic test_basic();
    logic [31:0] exp_addr [3];
    logic [31:0] exp_data [3];
    int lat; logic [31:0] p; logic e; bit ok;
    exp_addr[0] = 32'h7c80_0000; exp_data[0] = 32'd15;
    exp_addr[1] = 32'h7c80_0004; exp_data[1] = 32'd15;
    exp_addr[2] = 32'h7c80_0008; exp_data[2] = 32'd1;
    clear_log();
    start_job(16'd15, 16'd15, ok);
    if (job_ready !== 1'b0 || awvalid !== 1'b1 || wvalid !== 1'b1) begin
      errors++;
      $display("FAIL accept_edge: job_ready=%b awvalid=%b wvalid=%b expected 0 1 1",
               job_ready, awvalid, wvalid);
    end
    checks++;
    wait_result(lat, p, e);
    if (wr_count !== 3) begin
      errors++; $display("FAIL basic_wr_count: got %0d expected 3", wr_count);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      if (wr_addr_log[i] !== exp_addr[i] || wr_data_log[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL basic_write%0d: got %h=%h expected %h=%h",
                 i, wr_addr_log[i], wr_data_log[i], exp_addr[i], exp_data[i]);
      end
      checks++;
    end
    if (p !== 32'd225 || e !== 1'b0) begin
      errors++; $display("FAIL basic_result: got p=%0d err=%b expected 225 0", p, e);
    end
    checks++;
    if (lat !== 10) begin
      errors++; $display("FAIL basic_latency: got %0d expected 10", lat);
    end
    checks++;
    finish_res();
  endtask

  task automatic test_poll();
    int lat; logic [31:0] p; logic e; bit ok;
    clear_log();
    cfg_done_zeros = 2;
    start_job(16'hFFFF, 16'hFFFF, ok);
    wait_result(lat, p, e);
    cfg_done_zeros = 0;
    if (done_reads !== 3) begin
      errors++; $display("FAIL poll_done_reads: got %0d expected 3", done_reads);
    end
    checks++;
    if (p !== 32'hFFFE_0001 || e !== 1'b0) begin
      errors++; $display("FAIL poll_result: got p=%h err=%b expected fffe0001 0", p, e);
    end
    checks++;
    if (lat !== 14) begin
      errors++; $display("FAIL poll_latency: got %0d expected 14", lat);
    end
    checks++;
    finish_res();
  endtask

  task automatic test_timeout();
    int lat; logic [31:0] p; logic e; bit ok;
    clear_log();
    cfg_never_done = 1;
    start_job(16'd9, 16'd9, ok);
    wait_result(lat, p, e);
    cfg_never_done = 0;
    if (done_reads !== 4 || p_reads !== 0) begin
      errors++;
      $display("FAIL timeout_reads: got done=%0d p=%0d expected 4 0", done_reads, p_reads);
    end
    checks++;
    if (p !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL timeout_result: got p=%h err=%b expected 0 1", p, e);
    end
    checks++;
    finish_res();
  endtask

  task automatic test_bresp_err();
    int lat; logic [31:0] p; logic e; bit ok;
    clear_log();
    cfg_err_addr = BASE + 32'h4;
    start_job(16'd4, 16'd5, ok);
    wait_result(lat, p, e);
    cfg_err_addr = 32'h0;
    if (wr_count !== 2 || done_reads !== 0) begin
      errors++;
      $display("FAIL bresp_traffic: got writes=%0d done_reads=%0d expected 2 0",
               wr_count, done_reads);
    end
    checks++;
    if (p !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL bresp_result: got p=%h err=%b expected 0 1", p, e);
    end
    checks++;
    finish_res();
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] p; logic e; bit ok;
    clear_log();
    cfg_aw_delay = 3;
    start_job(16'd3, 16'd5, ok);
    wait_result(lat, p, e);
    cfg_aw_delay = 0;
    if (lat !== 19) begin
      errors++; $display("FAIL skew_latency: got %0d expected 19", lat);
    end
    checks++;
    if (stab_err !== 0) begin
      errors++; $display("FAIL skew_stability: got %0d violations expected 0", stab_err);
    end
    checks++;
    repeat (5) @(posedge clk);
    #1;
    if (res_valid !== 1'b1 || res_p !== 32'd15 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL hold_result: got valid=%b p=%0d err=%b expected 1 15 0",
               res_valid, res_p, res_err);
    end
    checks++;
    finish_res();
    start_job(16'd2, 16'd3, ok);
    wait_result(lat, p, e);
    if (p !== 32'd6 || lat !== 10) begin
      errors++; $display("FAIL next_job: got p=%0d lat=%0d expected 6 10", p, lat);
    end
    checks++;
    finish_res();
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] p; logic e; bit ok;
    clear_log();
    cfg_never_done = 1;
    start_job(16'd11, 16'd11, ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done_reads >= 1) begin ok = 1; break; end
    end
    if (!ok) begin
      errors++; $display("FAIL mid_poll_reached: done_reads=%0d expected >=1", done_reads);
    end
    checks++;
    areset = 1;
    @(posedge clk);
    #1;
    cfg_never_done = 0;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0 ||
        job_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valids=%b job_ready=%b res_valid=%b expected 00000 1 0",
               {awvalid, wvalid, bready, arvalid, rready}, job_ready, res_valid);
    end
    checks++;
    areset = 0;
    start_job(16'd7, 16'd6, ok);
    wait_result(lat, p, e);
    if (p !== 32'd42 || e !== 1'b0) begin
      errors++; $display("FAIL post_reset_job: got p=%0d err=%b expected 42 0", p, e);
    end
    checks++;
    finish_res();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_poll();
    test_timeout();
    test_bresp_err();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
